// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM port arbiter between instruction fetch (IF) and the
// MEM stage. The owner keeps the port until it drops its request, so that
// multi-byte accesses are never interleaved. MEM wins when both requesters
// arrive together at an idle port. Ownership passes directly from one
// requester to the other, without an idle cycle in between.
// Address, write data and the write strobe come combinationally from the
// registered owner. RAM read data is forwarded unchanged to both requesters.
module mem_ctrl #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_request,
  input  logic [31:0]       if_addr,
  output logic [7:0]        if_data_o,
  input  logic [1:0]        mem_request,
  input  logic [31:0]       mem_addr,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        mem_data_o,
  output logic [1:0]        if_or_mem,
  output logic              mem_wait,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr
);

  // The state encoding doubles as the if_or_mem owner code.
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] IF_BUSY  = 2'b01;
  localparam logic [1:0] MEM_BUSY = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       mem_req;
  logic       mem_store;
  logic       io_region;

  // A mem_request of 11 counts as no request.
  assign mem_req   = (mem_request == 2'b01) || (mem_request == 2'b10);
  assign mem_store = (mem_request == 2'b10);
  assign io_region = (mem_addr[17:16] == 2'b11);

  // Next owner. The grant is locked while the owner keeps requesting.
  // On release, the port goes straight to the other requester if it is waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_req)         state_nxt = MEM_BUSY;
        else if (if_request) state_nxt = IF_BUSY;
      end
      IF_BUSY: begin
        if (!if_request)     state_nxt = mem_req ? MEM_BUSY : IDLE;
      end
      MEM_BUSY: begin
        if (!mem_req)        state_nxt = if_request ? IF_BUSY : IDLE;
      end
      default:               state_nxt = IDLE;
    endcase
  end

  // Owner register. It is frozen while rdy=0 and cleared immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  assign if_or_mem = state;

  // An I/O-region store stalls while the I/O buffer is full.
  // The stall does not depend on rdy, so MEM still sees the hold while frozen.
  assign mem_wait = (state == MEM_BUSY) && mem_store && io_region && io_buffer_full;

  // Route the owner's address and data to the RAM.
  // A write is issued only for a running store that is not held.
  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    case (state)
      IF_BUSY: begin
        ram_a = if_addr[RAM_AW-1:0];
      end
      MEM_BUSY: begin
        ram_a    = mem_addr[RAM_AW-1:0];
        ram_dout = mem_data_i;
        ram_wr   = rdy && mem_store && !mem_wait;
      end
      default: ;
    endcase
  end

  // The RAM read is synchronous with one cycle of latency, so the data needs no
  // staging here. Each requester samples it only in cycles when it owns the port.
  assign if_data_o  = ram_din;
  assign mem_data_o = ram_din;

endmodule
